clb_cfg_sequencer: RTL
======================

# clb_cfg_sequencer

Configuration sequencer sitting between the external bitstream port and an array of CLBs in the tiny FPGA fabric. On `start` it walks CLBs 0..NUM_CLBS-1 in order: pulses each CLB's `cfg`, routes one AXI-stream frame (ending on `tlast`) to that CLB, then waits for its `cfg_ready` before moving on. It reports completion with a `done` pulse and flags a stalled CLB through a sticky timeout error.

## Interface
Parameters:
- `NUM_CLBS`, 4, number of CLBs configured per sequence (≥1)
- `DATA_WIDTH`, 8, bitstream beat width
- `TIMEOUT_CYCLES`, 255, maximum cycles spent in WAIT per CLB (≥1)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1, fabric clock
- `rst` in 1, asynchronous active-high reset
- `start` in 1, begin a configuration sequence; sampled only in IDLE
- `busy` out 1, high in every state except IDLE
- `done` out 1, one-cycle pulse when the last CLB has reported ready
- `err` out 1, sticky timeout flag; cleared by `rst` or an accepted `start`
- `cur_clb` out $clog2(NUM_CLBS) (min 1), index of the CLB being configured
- `s_tdata` in DATA_WIDTH, `s_tvalid` in 1, `s_tlast` in 1, `s_tready` out 1: bitstream slave
- `m_tdata` out DATA_WIDTH, `m_tlast` out 1, shared across CLBs
- `m_tvalid` out NUM_CLBS, `m_tready` in NUM_CLBS: per-CLB stream handshake
- `clb_cfg` out NUM_CLBS, per-CLB configuration-begin pulse
- `clb_cfg_ready` in NUM_CLBS, per-CLB configuration-complete level

## Operation
- States: IDLE, SELECT, STREAM, WAIT, NEXT, DONE, ERROR.
- IDLE: `start` → SELECT with `cur_clb`=0 and `err` cleared.
- SELECT: `clb_cfg[cur_clb]`=1 for exactly this cycle → STREAM.
- STREAM: combinational pass-through. `m_tdata`=`s_tdata`, `m_tlast`=`s_tlast`, `m_tvalid[cur_clb]`=`s_tvalid`, all other `m_tvalid` bits 0, `s_tready`=`m_tready[cur_clb]`. A beat with `s_tvalid`&`s_tready`&`s_tlast` → WAIT.
- WAIT: the timeout counter clears on entry and increments each cycle. `clb_cfg_ready[cur_clb]` → NEXT. Otherwise, counter==TIMEOUT_CYCLES-1 → ERROR. If ready and timeout coincide, ready wins.
- NEXT: `cur_clb`==NUM_CLBS-1 → DONE; otherwise increment `cur_clb` → SELECT.
- DONE: `done`=1 for one cycle → IDLE.
- ERROR: sets `err`, holds until next cycle → IDLE. `cur_clb` keeps the failing index until the next `start`.
- Outside STREAM: `s_tready`=0, `m_tvalid`=0. `clb_cfg` is 0 outside SELECT.
- `start` outside IDLE is ignored. Stray `s_tvalid` outside STREAM is not consumed.
- `cur_clb` never exceeds NUM_CLBS-1, so there is no wrap-around.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `cur_clb` 0, `s_tready` 0, `m_tvalid` 0, `clb_cfg` 0, counter 0. `m_tdata`/`m_tlast` follow the input (don't-care).
- `rst` asserted mid-sequence forces all of the above immediately (asynchronously). Nothing resumes after release; a new `start` is required.
- Latency per CLB: `start`→`clb_cfg` is 1 cycle. `clb_cfg` → first routable beat: next cycle. Final beat → WAIT: next cycle. Ready in WAIT → NEXT +1 → SELECT/DONE +1.
- Minimum sequence with 1-beat frames and immediate ready: 4 cycles per CLB from SELECT to the next SELECT.
- Stream path has zero added latency, and there are no registers on data.

## Structure
- Shared package `tiny_fpga_pkg` holds the `t_cfg_seq_state` enum (3-bit) and a `clog2_min1` helper constant function.
- Sub-module `cfg_timeout_counter`: clear, enable, and an `expired` flag at TIMEOUT_CYCLES-1. Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Everything else lives in a single FSM module.

## Test plan
- NUM_CLBS=4, 3-beat frames 0xA1..0xA3 per CLB, ready 2 cycles after `tlast`. Required: each CLB sees only its own 3 beats with `tlast` on the third; `clb_cfg` pulses at 0,1,2,3 in order; `done` pulses once; `busy` drops the cycle after `done`.
- `m_tready[1]` held low for 5 cycles mid-frame. Required: `s_tready`=0 for those 5 cycles, no beat is lost or duplicated, and the frame completes after release.
- CLB 2 never asserts ready, TIMEOUT_CYCLES=8. Required: ERROR entered exactly 8 cycles after entering WAIT; `err`=1 sticky, `cur_clb`=2, no `done`; the next `start` clears `err` and restarts at CLB 0.
- Ready asserted on the same cycle the timeout expires. Required: NEXT is taken and `err` stays 0.
- `rst` pulsed during STREAM of CLB 1. Required: outputs take reset values within the same cycle, and `start` after release configures from CLB 0.
- `start` held high throughout a sequence, plus `s_tvalid` high in IDLE. Required: exactly one sequence per IDLE entry, and `s_tready`=0 in IDLE.

Source files
------------

// File: rtl/tiny_fpga_pkg.sv
// rtl/tiny_fpga_pkg.sv - shared types and helpers for the tiny FPGA fabric
package tiny_fpga_pkg;

   // Configuration sequencer states, 3-bit encoded
   typedef enum logic [2:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_SELECT = 3'd1,
      SEQ_STREAM = 3'd2,
      SEQ_WAIT   = 3'd3,
      SEQ_NEXT   = 3'd4,
      SEQ_DONE   = 3'd5,
      SEQ_ERROR  = 3'd6
   } t_cfg_seq_state;

   // Bits needed to index 'value' items, never less than one so a
   // single-item array still gets a real port
   function automatic int clog2_min1(input int value);
      int width;
      width = 1;
      while ((64'd1 << width) < 64'(value)) begin
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/cfg_timeout_counter.sv
// rtl/cfg_timeout_counter.sv - per-CLB ready timeout counter
module cfg_timeout_counter
   import tiny_fpga_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Clear wins over enable; the count parks at the limit instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/clb_cfg_sequencer.sv
// rtl/clb_cfg_sequencer.sv - walks the CLB array, routing one bitstream frame to each
module clb_cfg_sequencer
   import tiny_fpga_pkg::*;
#(
   parameter int  NUM_CLBS       = 4,
   parameter int  DATA_WIDTH     = 8,
   parameter int  TIMEOUT_CYCLES = 255,
   localparam int IDX_W          = clog2_min1(NUM_CLBS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [IDX_W-1:0]      cur_clb,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic [NUM_CLBS-1:0]   m_tvalid,
   input  logic [NUM_CLBS-1:0]   m_tready,
   output logic [NUM_CLBS-1:0]   clb_cfg,
   input  logic [NUM_CLBS-1:0]   clb_cfg_ready
);

   localparam logic [IDX_W-1:0] LAST_CLB = IDX_W'(NUM_CLBS - 1);

   t_cfg_seq_state         state;
   t_cfg_seq_state         state_next;
   logic [IDX_W-1:0]       clb_idx;
   logic [NUM_CLBS-1:0]    clb_sel;
   logic                   sel_tready;
   logic                   sel_cfg_ready;
   logic                   wait_expired;

   // One-hot select of the CLB being configured; avoids indexing past
   // NUM_CLBS when the index width covers more codes than CLBs
   assign clb_sel       = NUM_CLBS'(1) << clb_idx;
   assign sel_tready    = |(m_tready & clb_sel);
   assign sel_cfg_ready = |(clb_cfg_ready & clb_sel);

   // Data and last are broadcast unregistered; only valid is steered
   assign m_tdata = s_tdata;
   assign m_tlast = s_tlast;
   assign cur_clb = clb_idx;

   cfg_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (state != SEQ_WAIT),
      .enable (state == SEQ_WAIT),
      .expired(wait_expired)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEQ_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and all state-decoded outputs
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      s_tready   = 1'b0;
      m_tvalid   = '0;
      clb_cfg    = '0;
      case (state)
         SEQ_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = SEQ_SELECT;
            end
         end
         SEQ_SELECT: begin
            clb_cfg    = clb_sel;
            state_next = SEQ_STREAM;
         end
         SEQ_STREAM: begin
            s_tready = sel_tready;
            m_tvalid = s_tvalid ? clb_sel : '0;
            if (s_tvalid && sel_tready && s_tlast) begin
               state_next = SEQ_WAIT;
            end
         end
         SEQ_WAIT: begin
            // A ready arriving on the expiry cycle still counts as success
            if (sel_cfg_ready) begin
               state_next = SEQ_NEXT;
            end else if (wait_expired) begin
               state_next = SEQ_ERROR;
            end
         end
         SEQ_NEXT: begin
            state_next = (clb_idx == LAST_CLB) ? SEQ_DONE : SEQ_SELECT;
         end
         SEQ_DONE: begin
            done       = 1'b1;
            state_next = SEQ_IDLE;
         end
         SEQ_ERROR: begin
            state_next = SEQ_IDLE;
         end
         default: begin
            state_next = SEQ_IDLE;
         end
      endcase
   end

   // CLB index and sticky error: both restart on an accepted start; the
   // index is left on the failing CLB after a timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clb_idx <= '0;
         err     <= 1'b0;
      end else begin
         if (state == SEQ_IDLE && start) begin
            clb_idx <= '0;
            err     <= 1'b0;
         end else if (state == SEQ_NEXT && clb_idx != LAST_CLB) begin
            clb_idx <= clb_idx + IDX_W'(1);
         end
         if (state == SEQ_WAIT && state_next == SEQ_ERROR) begin
            err <= 1'b1;
         end
      end
   end

endmodule
